// File: rtl/piezo_pkg.sv
// rtl/piezo_pkg.sv - shared constants, FSM states and key priority helper for the piezo key encoder
// Purpose: common types for piezo_key_encoder, its interface and key_debounce.
// Ports: none (package).
package piezo_pkg;

    localparam int NUM_KEYS = 10;
    localparam int CODE_W   = 4;
    localparam logic [CODE_W-1:0] IDLE_CODE_DEF = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        SUSTAIN = 2'd2
    } state_e;

    // Index of the lowest set bit; the lowest digit wins when several keys are down.
    // Returns 0 for an empty vector, callers qualify with |v.
    function automatic logic [CODE_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/piezo_key_encoder_if.sv
// rtl/piezo_key_encoder_if.sv - keypad-to-tone-selector signal bundle for the piezo key encoder
// Purpose: groups raw keys and the encoder results.
// Signals: key (raw buttons), regi (tone code), tone_en, key_evt (one-cycle), key_code.
// Modports: master = keypad/consumer side, slave = encoder side.
interface piezo_key_encoder_if;
    import piezo_pkg::*;

    logic [NUM_KEYS-1:0] key;
    logic [CODE_W-1:0]   regi;
    logic                tone_en;
    logic                key_evt;
    logic [CODE_W-1:0]   key_code;

    modport master (
        output key,
        input  regi, tone_en, key_evt, key_code
    );

    modport slave (
        input  key,
        output regi, tone_en, key_evt, key_code
    );

endinterface

// File: rtl/piezo_key_encoder_debounce.sv
// rtl/piezo_key_encoder_debounce.sv - two-flop synchroniser plus stable-vector debounce filter
// Purpose: kst_o follows the synchronised key vector only after it has stayed
//          unchanged for DEB_CYCLES consecutive cycles.
// Ports: clk, rst (sync, active-high), key_i (raw async keys), kst_o (debounced vector).
module key_debounce #(
    parameter int WIDTH      = 10,
    parameter int DEB_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key_i,
    output logic [WIDTH-1:0] kst_o
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] ks_q, ks_d;
    logic [WIDTH-1:0] kst_q, kst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ks_change;

    // sync1_q is the value ks takes at the next edge, so a mismatch means ks is
    // changing this cycle and the stability count restarts with it.
    assign ks_change = (sync1_q != ks_q);

    always_comb begin
        sync1_d = key_i;
        ks_d    = sync1_q;
        cnt_d   = cnt_q;
        kst_d   = kst_q;
        if (ks_change) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q >= CNT_ACC) begin
                kst_d = ks_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            ks_q    <= '0;
            kst_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            ks_q    <= ks_d;
            kst_q   <= kst_d;
            cnt_q   <= cnt_d;
        end
    end

    assign kst_o = kst_q;

endmodule

// File: rtl/piezo_key_encoder.sv
// rtl/piezo_key_encoder.sv - debounced, priority-encoded keypad to piezo tone-select code
// Purpose: turns ten key lines into the 4-bit tone code regi with a minimum tone time.
// Ports: clk, rst (sync, active-high), bus (slave): key in; regi, tone_en,
//        key_evt, key_code out.
module piezo_key_encoder
    import piezo_pkg::*;
#(
    parameter int                DEB_CYCLES = 20000,
    parameter int                MIN_HOLD   = 50000,
    parameter logic [CODE_W-1:0] IDLE_CODE  = IDLE_CODE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    piezo_key_encoder_if.slave   bus
);

    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);

    logic [NUM_KEYS-1:0] kst;
    logic [CODE_W-1:0]   pe;
    logic                any_key;
    logic                retrig;
    logic                load;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CODE_W-1:0]   regi_q, regi_d;
    logic [CODE_W-1:0]   key_code_q, key_code_d;
    logic                key_evt_q, key_evt_d;
    logic                tone_en_q, tone_en_d;

    key_debounce #(
        .WIDTH      (NUM_KEYS),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .key_i (bus.key),
        .kst_o (kst)
    );

    assign pe      = lowest_set(kst);
    assign any_key = |kst;
    // A different winning digit while a tone plays restarts the tone on it.
    assign retrig  = any_key && (pe != regi_q);
    assign load    = (state_q == IDLE) ? any_key : retrig;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            regi_q     <= IDLE_CODE;
            key_code_q <= '0;
            key_evt_q  <= 1'b0;
            tone_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            regi_q     <= regi_d;
            key_code_q <= key_code_d;
            key_evt_q  <= key_evt_d;
            tone_en_q  <= tone_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (any_key) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                if (retrig) begin
                    hold_d = '0;
                end else begin
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                    if (hold_q == HOLD_LAST) begin
                        state_d = SUSTAIN;
                    end
                end
            end
            SUSTAIN: begin
                if (!any_key) begin
                    state_d = IDLE;
                end else if (retrig) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        regi_d     = regi_q;
        key_code_d = key_code_q;
        key_evt_d  = 1'b0;
        if (load) begin
            regi_d     = pe;
            key_code_d = pe;
            key_evt_d  = 1'b1;
        end else if ((state_q == SUSTAIN) && !any_key) begin
            regi_d = IDLE_CODE;
        end
        // Registered from the next regi so tone_en and regi switch on the same edge.
        tone_en_d = (regi_d != IDLE_CODE);
    end

    assign bus.regi     = regi_q;
    assign bus.key_code = key_code_q;
    assign bus.key_evt  = key_evt_q;
    assign bus.tone_en  = tone_en_q;

endmodule

// File: doc/piezo_key_encoder.md
Name: piezo_key_encoder

Overview:
- Front end for the piezo tone path: turns 10 raw push-button lines (digits 0-9) into the 4-bit tone-select code `regi` consumed by the 10-way tone selector.
- Synchronises, debounces and priority-encodes the keys.
- Holds the selected code for at least a minimum tone time, then returns to the silence code.
- Sits between the keypad pins and the tone selector; also emits a one-cycle key event for the control logic.

Parameters:
- DEB_CYCLES, 20000, consecutive identical sampled key vectors required before a change is accepted (1..65535).
- MIN_HOLD, 50000, minimum cycles `regi` holds a digit code after acceptance, even if the key is released earlier (1..2^20-1).
- IDLE_CODE, 4'd15, code driven on `regi` when no tone is requested; maps to a tied-zero selector input.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- key  input  10  raw asynchronous buttons, bit n = digit n, active-high
- regi  output  4  tone-select code: digit 0..9, or IDLE_CODE
- tone_en  output  1  high while `regi` holds a digit code
- key_evt  output  1  one-cycle pulse when a new digit is accepted
- key_code  output  4  digit accepted at the last `key_evt`; held until the next `key_evt`

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high; `rst` sampled on the rising `clk` edge.
  - Reset values: `regi`=IDLE_CODE, `tone_en`=0, `key_evt`=0, `key_code`=0.
  - Reset values: synchroniser flops 0, debounce counter 0, hold counter 0, state IDLE.
- Input synchronisation:
  - `key` passes through a 2-flop synchroniser to give `ks`.
  - Stable vector `kst` (reset 0) updates to `ks` only when `ks` has been unchanged for DEB_CYCLES consecutive cycles.
  - Any change in `ks` restarts the debounce count at 0.
  - Counter width is clog2(DEB_CYCLES+1); it saturates, never wraps.
- Priority encode:
  - `pe` = index of the lowest set bit of `kst`.
  - `any` = |kst.
  - Multiple keys pressed: the lowest digit wins (e.g. keys 3 and 7 give 3).
- State machine:
  - IDLE:
    - `regi`=IDLE_CODE, `tone_en`=0.
    - On `any`: `regi`<=`pe`, `key_code`<=`pe`, `key_evt`=1 for that cycle, hold counter<=0, go to HOLD.
  - HOLD:
    - `tone_en`=1; hold counter increments, saturating at MIN_HOLD.
    - If `any` and `pe`!=`regi`: retrigger. `regi`/`key_code`<=`pe`, `key_evt` pulse, hold counter<=0, stay in HOLD.
    - Else, when the counter reaches MIN_HOLD-1: go to SUSTAIN.
  - SUSTAIN:
    - `tone_en`=1.
    - `!any`: `regi`<=IDLE_CODE, go to IDLE.
    - `any` and `pe`!=`regi`: retrigger as in HOLD, go to HOLD.
    - Same key still held: stay.
- Timing:
  - Latency from a clean `key` edge to the `regi` update is 2 + DEB_CYCLES + 1 cycles.
  - `regi` and `tone_en` are registered and glitch-free.
  - `key_evt` is registered, coincident with the `regi` update.
- Boundary conditions:
  - A release during HOLD does not silence the tone before MIN_HOLD has elapsed.
  - A press and release both shorter than DEB_CYCLES are ignored entirely.
  - Bouncing within the debounce window produces no `key_evt`.
  - `rst` asserted mid-tone: the next cycle shows reset values, with no `key_evt`.
  - A key held through reset release is re-accepted only after a full debounce.
  - `regi` never takes values 10..14; IDLE_CODE is the only non-digit value.

Decomposition:
- Shared package `piezo_pkg`:
  - constants NUM_KEYS=10, CODE_W=4, IDLE_CODE default
  - state enum {IDLE, HOLD, SUSTAIN}
  - function `lowest_set(10-bit) -> 4-bit`
- One sub-module `key_debounce`, containing the synchroniser plus stable-vector filter, parameterised by width and DEB_CYCLES. The top level holds the encoder and FSM.

Test Plan:
- Reset, no keys; sim with DEB_CYCLES=4, MIN_HOLD=8 -> `regi`=15, `tone_en`=0, `key_evt` never asserts over 100 cycles.
- Clean press of key[5] held 40 cycles, then released:
  - `key_evt` pulses exactly once, 7 cycles after the edge, with `key_code`=5, `regi`=5.
  - `regi` returns to 15 seven cycles after the release edge.
- key[2] press of 6 cycles -> tone accepted; `regi`=2 holds for a full 8 cycles after acceptance even though released, then 15.
- key[9] bouncing 0/1 every 2 cycles for 20 cycles, then held -> exactly one `key_evt`, `key_code`=9.
- key[7] held, then key[3] added -> retrigger: `key_evt` pulse, `regi`=3; releasing key[3] gives `regi`=7 with a second `key_evt`.
- `rst` asserted while `regi`=4 in SUSTAIN -> next cycle `regi`=15, `tone_en`=0; with key[4] still held, re-acceptance occurs 7 cycles after `rst` deasserts.
